// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg -- shared definitions for the instruction fetch queue.
//   JAL_OPCODE     : opcode of the direct jump recognised by the predictor
//   FETCH/WAIT/DROP: fetch FSM state encodings (2 bits)
//   iq_entry_t     : one queue entry {pred, pc, inst}
//   jal_imm()      : sign-extended J-type immediate of an instruction word
package ifetch_queue_pkg;

   localparam logic [6:0] JAL_OPCODE = 7'b1101111;

   localparam logic [1:0] FETCH = 2'd0;
   localparam logic [1:0] WAIT  = 2'd1;
   localparam logic [1:0] DROP  = 2'd2;

   typedef struct packed {
      logic        pred;
      logic [31:0] pc;
      logic [31:0] inst;
   } iq_entry_t;

   localparam int IQ_ENTRY_W = $bits(iq_entry_t);

   // immJ = sext({w[31], w[19:12], w[20], w[30:21], 1'b0})
   function automatic logic [31:0] jal_imm(input logic [31:0] w);
      return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo -- circular buffer with first-word-fall-through head.
//   clk, rst        : clock, synchronous active-high reset (clears storage too)
//   en              : global ready; low freezes every register
//   clear           : drop all entries (wins over push/pop)
//   push, push_data : write push_data at tail; caller guarantees a free slot
//   pop             : advance head; ignored while empty
//   head_data       : entry at head, combinational off the storage
//   count           : number of valid entries (0..DEPTH)
module ifetch_fifo
   import ifetch_queue_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = IQ_ENTRY_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   clear,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head_data,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    head;
   logic [AW-1:0]    tail;
   logic             do_pop;

   assign do_pop    = pop && (count != '0);
   assign head_data = mem[head];

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (en) begin
         if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (push) begin
               mem[tail] <= push_data;
               tail      <= tail + 1'b1;
            end
            if (do_pop) head <= head + 1'b1;
            // Push and pop together leave the occupancy unchanged.
            case ({push, do_pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue -- instruction fetch stage with a buffering instruction queue.
// Fetches one word at a time from the memory controller, buffers each word
// with its PC and presents the oldest one first-word-fall-through.
//   clk_in, rst_in, rdy_in    : clock, sync active-high reset, global freeze
//   mem_req_valid/_addr       : single outstanding word request
//   mem_resp_valid/_data      : one-cycle response for the outstanding request
//   inst_valid/_out/_pc       : queue head towards the dispatcher/decoder
//   inst_pred_taken           : head was predicted taken
//   inst_ready                : dispatcher consumes the head this cycle
//   flush_in, flush_pc        : redirect from the ROB (highest priority)
// Build option: define IFETCH_JAL_PREDICT_EN to follow JAL targets when
// fetching; otherwise fetch is strictly sequential and pred is always 0.
// Handshake: a word moves on the response side when mem_resp_valid is high
// while a request is outstanding, and on the dispatch side when inst_valid
// and inst_ready are both high in the same cycle.
module ifetch_queue
   import ifetch_queue_pkg::*;
#(
   parameter int          IQ_DEPTH = 16,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   output logic        mem_req_valid,
   output logic [31:0] mem_req_addr,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic        inst_valid,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   output logic        inst_pred_taken,
   input  logic        inst_ready,
   input  logic        flush_in,
   input  logic [31:0] flush_pc
);

   localparam int             CW      = $clog2(IQ_DEPTH) + 1;
   localparam logic [CW-1:0]  DEPTH_C = CW'(IQ_DEPTH);

   logic [1:0]            state;
   logic [31:0]           pc;
   logic [31:0]           next_pc;
   logic                  pred;
   logic [CW-1:0]         count;
   logic                  push;
   logic                  pop;
   iq_entry_t             push_entry;
   logic [IQ_ENTRY_W-1:0] head_bits;
   iq_entry_t             head_entry;

   // A response landing in the flush cycle belongs to the old path.
   assign push = (state == WAIT) && mem_resp_valid && !flush_in;
   assign pop  = inst_valid && inst_ready && !flush_in;

   always_comb begin
      next_pc = pc + 32'd4;
      pred    = 1'b0;
`ifdef IFETCH_JAL_PREDICT_EN
      if (mem_resp_data[6:0] == JAL_OPCODE) begin
         next_pc = pc + jal_imm(mem_resp_data);
         pred    = 1'b1;
      end
`endif
   end

   assign push_entry = '{pred: pred, pc: pc, inst: mem_resp_data};

   ifetch_fifo #(
      .DEPTH (IQ_DEPTH),
      .WIDTH (IQ_ENTRY_W)
   ) u_fifo (
      .clk       (clk_in),
      .rst       (rst_in),
      .en        (rdy_in),
      .clear     (flush_in),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head_data (head_bits),
      .count     (count)
   );

   assign head_entry      = head_bits;
   assign inst_valid      = (count != '0);
   assign inst_out        = head_entry.inst;
   assign inst_pc         = head_entry.pc;
   assign inst_pred_taken = head_entry.pred;

   // A request is only launched while the queue has a free slot; that slot
   // stays reserved for the in-flight word regardless of pops meanwhile.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state         <= FETCH;
         pc            <= RESET_PC;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
      end else if (rdy_in) begin
         if (flush_in) begin
            pc <= flush_pc;
            case (state)
               // An outstanding request cannot be cancelled: wait out its
               // response in DROP unless it is arriving right now.
               WAIT, DROP: begin
                  if (mem_resp_valid) begin
                     state         <= FETCH;
                     mem_req_valid <= 1'b0;
                  end else begin
                     state <= DROP;
                  end
               end
               default: state <= FETCH;
            endcase
         end else begin
            case (state)
               FETCH: begin
                  if (count < DEPTH_C) begin
                     state         <= WAIT;
                     mem_req_valid <= 1'b1;
                     mem_req_addr  <= pc;
                  end
               end
               WAIT: begin
                  if (mem_resp_valid) begin
                     pc            <= next_pc;
                     state         <= FETCH;
                     mem_req_valid <= 1'b0;
                  end
               end
               DROP: begin
                  if (mem_resp_valid) begin
                     state         <= FETCH;
                     mem_req_valid <= 1'b0;
                  end
               end
               default: begin
                  state         <= FETCH;
                  mem_req_valid <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue -- bench for ifetch_queue (IQ_DEPTH=4). The bench plays
// the memory controller (fixed 3-cycle response) and keeps a queue model of
// fetched words, checked every cycle, plus directed literal expectations.
module tb_ifetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RST_PC   = 32'h0;
   localparam int          RESP_LAT = 3;
`ifdef IFETCH_JAL_PREDICT_EN
   localparam logic [31:0] JAL_NEXT = 32'h28;
   localparam logic        JAL_PRED = 1'b1;
`else
   localparam logic [31:0] JAL_NEXT = 32'h24;
   localparam logic        JAL_PRED = 1'b0;
`endif

   typedef struct {
      logic [31:0] w;
      logic [31:0] pc;
      logic        pred;
   } ent_t;

   // ---------------- clock / DUT ----------------
   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, inst_ready, flush_in;
   logic [31:0] flush_pc;
   logic        mem_req_valid, mem_resp_valid;
   logic [31:0] mem_req_addr, mem_resp_data;
   logic        inst_valid, inst_pred_taken;
   logic [31:0] inst_out, inst_pc;

   always #5 clk_in = ~clk_in;

   ifetch_queue #(.IQ_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .rdy_in          (rdy_in),
      .mem_req_valid   (mem_req_valid),
      .mem_req_addr    (mem_req_addr),
      .mem_resp_valid  (mem_resp_valid),
      .mem_resp_data   (mem_resp_data),
      .inst_valid      (inst_valid),
      .inst_out        (inst_out),
      .inst_pc         (inst_pc),
      .inst_pred_taken (inst_pred_taken),
      .inst_ready      (inst_ready),
      .flush_in        (flush_in),
      .flush_pc        (flush_pc)
   );

   // ---------------- bench state ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          resp_cnt = 0;
   logic        prev_req = 1'b0;
   logic        stale = 1'b0;
   logic [31:0] mpc = RST_PC;
   ent_t        mq[$];
   int          req_cyc_q[$];
   logic [31:0] req_addr_q[$];
   logic [31:0] pop_pc_q[$];
   logic [31:0] pop_w_q[$];
   logic        pop_p_q[$];
   logic        force_en = 1'b0;
   logic [31:0] force_data = '0;
   logic        jal_mode = 1'b0;
   logic        flush_at_resp = 1'b0;
   logic [31:0] flush_at_resp_pc = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (jal_mode && a == 32'h20) return 32'h0080006F;
      return {a[24:0], 7'h13};
   endfunction

   function automatic logic model_pred(input logic [31:0] w);
`ifdef IFETCH_JAL_PREDICT_EN
      return (w[6:0] == 7'b1101111);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w);
      logic [20:0] imm;
      imm = {w[31], w[19:12], w[20], w[30:21], 1'b0};
      if (model_pred(w)) return p + {{11{imm[20]}}, imm};
      return p + 32'd4;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- model ----------------
   task automatic model_update();
      ent_t e;
      ent_t drop;
      if (rst_in) begin
         mq.delete();
         mpc   = RST_PC;
         stale = 1'b0;
      end else if (rdy_in) begin
         if (flush_in) begin
            mq.delete();
            mpc   = flush_pc;
            stale = (mem_req_valid === 1'b1) && !mem_resp_valid;
         end else begin
            if (inst_ready && mq.size() != 0) drop = mq.pop_front();
            if (mem_resp_valid) begin
               if (stale) begin
                  stale = 1'b0;
               end else begin
                  e.w    = mem_resp_data;
                  e.pc   = mpc;
                  e.pred = model_pred(mem_resp_data);
                  mq.push_back(e);
                  mpc = model_next(mpc, mem_resp_data);
               end
            end
         end
      end
   endtask

   // ---------------- scoreboard compare (every cycle) ----------------
   task automatic compare();
      if (mem_req_valid === 1'b1 && prev_req !== 1'b1) begin
         req_cyc_q.push_back(cyc);
         req_addr_q.push_back(mem_req_addr);
      end
      prev_req = mem_req_valid;
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, mq.size() != 0});
      if (mq.size() != 0) begin
         chk("inst_out", inst_out, mq[0].w);
         chk("inst_pc", inst_pc, mq[0].pc);
         chk("inst_pred", {31'b0, inst_pred_taken}, {31'b0, mq[0].pred});
      end
      if (mem_req_valid === 1'b1 && !stale) begin
         chk("req_addr", mem_req_addr, mpc);
         chk("req_space", {31'b0, mq.size() < DEPTH}, 32'd1);
      end
   endtask

   // ---------------- driver: one clock cycle ----------------
   task automatic step();
      if (rst_in || mem_req_valid !== 1'b1) begin
         mem_resp_valid = 1'b0;
         resp_cnt       = 0;
      end else if (!rdy_in) begin
         mem_resp_valid = 1'b0;
      end else if (resp_cnt == RESP_LAT - 1) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = force_en ? force_data : mem_word(mem_req_addr);
         force_en       = 1'b0;
         resp_cnt       = 0;
      end else begin
         mem_resp_valid = 1'b0;
         resp_cnt++;
      end
      if (!mem_resp_valid) mem_resp_data = $urandom;
      if (flush_at_resp && mem_resp_valid) begin
         flush_in      = 1'b1;
         flush_pc      = flush_at_resp_pc;
         inst_ready    = 1'b1;
         flush_at_resp = 1'b0;
      end
      if (!rst_in && rdy_in && !flush_in && inst_valid === 1'b1 && inst_ready) begin
         pop_pc_q.push_back(inst_pc);
         pop_w_q.push_back(inst_out);
         pop_p_q.push_back(inst_pred_taken);
      end
      model_update();
      @(posedge clk_in);
      @(negedge clk_in);
      cyc++;
      compare();
   endtask

   task automatic run_until_reqs(input int n, input string tag);
      int i = 0;
      while (req_addr_q.size() < n && i < 300) begin
         step();
         i++;
      end
      chk({"req_timeout_", tag}, {31'b0, req_addr_q.size() >= n}, 32'd1);
   endtask

   task automatic run_until_pops(input int n, input string tag);
      int i = 0;
      while (pop_pc_q.size() < n && i < 300) begin
         step();
         i++;
      end
      chk({"pop_timeout_", tag}, {31'b0, pop_pc_q.size() >= n}, 32'd1);
   endtask

   task automatic do_reset();
      rst_in     = 1'b1;
      rdy_in     = 1'b1;
      flush_in   = 1'b0;
      inst_ready = 1'b0;
      jal_mode   = 1'b0;
      force_en   = 1'b0;
      step();
      step();
      chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
      chk("rst_req_addr", mem_req_addr, 32'h0);
      chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_inst_out", inst_out, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_inst_pred", {31'b0, inst_pred_taken}, 32'd0);
      rst_in = 1'b0;
      req_cyc_q.delete();
      req_addr_q.delete();
      pop_pc_q.delete();
      pop_w_q.delete();
      pop_p_q.delete();
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int rel;
      rst_in = 1'b1; rdy_in = 1'b1; inst_ready = 1'b0; flush_in = 1'b0;
      flush_pc = '0; mem_resp_valid = 1'b0; mem_resp_data = '0;
      @(negedge clk_in);

      // T1: sequential streaming, consumer always ready
      do_reset();
      inst_ready = 1'b1;
      rel = cyc;
      run_until_reqs(3, "t1");
      chk("t1_first_req_lat", req_cyc_q[0] - rel, 32'd1);
      chk("t1_req0", req_addr_q[0], 32'h0);
      chk("t1_req1", req_addr_q[1], 32'h4);
      chk("t1_req2", req_addr_q[2], 32'h8);
      chk("t1_gap01", req_cyc_q[1] - req_cyc_q[0], 32'd4);
      chk("t1_gap12", req_cyc_q[2] - req_cyc_q[1], 32'd4);
      run_until_pops(3, "t1");
      chk("t1_pop_pc0", pop_pc_q[0], 32'h0);
      chk("t1_pop_pc1", pop_pc_q[1], 32'h4);
      chk("t1_pop_pc2", pop_pc_q[2], 32'h8);
      chk("t1_pop_w0", pop_w_q[0], 32'h00000013);
      chk("t1_pop_w1", pop_w_q[1], 32'h00000213);
      chk("t1_pop_w2", pop_w_q[2], 32'h00000413);

      // T2: consumer stalled -> queue fills to DEPTH, then one pop
      do_reset();
      inst_ready = 1'b0;
      repeat (40) step();
      chk("t2_req_count_full", req_addr_q.size(), 32'd4);
      chk("t2_req3", req_addr_q[3], 32'hC);
      chk("t2_head_pc", inst_pc, 32'h0);
      chk("t2_req_idle", {31'b0, mem_req_valid}, 32'd0);
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      repeat (12) step();
      chk("t2_req_count_after_pop", req_addr_q.size(), 32'd5);
      chk("t2_req4", req_addr_q[4], 32'h10);
      chk("t2_head_pc_after_pop", inst_pc, 32'h4);

      // T3: flush while waiting; stale response two cycles later is dropped
      do_reset();
      run_until_reqs(3, "t3");
      force_en   = 1'b1;
      force_data = 32'hDEADBEEF;
      flush_in   = 1'b1;
      flush_pc   = 32'h100;
      step();
      flush_in = 1'b0;
      chk("t3_empty_after_flush", {31'b0, inst_valid}, 32'd0);
      run_until_reqs(4, "t3");
      chk("t3_req_after_flush", req_addr_q[3], 32'h100);
      inst_ready = 1'b1;
      run_until_pops(1, "t3");
      chk("t3_pop_pc", pop_pc_q[0], 32'h100);
      chk("t3_pop_w", pop_w_q[0], 32'h00008013);

      // T4: flush coincident with a response and inst_ready
      do_reset();
      run_until_reqs(3, "t4");
      flush_at_resp    = 1'b1;
      flush_at_resp_pc = 32'h200;
      for (int i = 0; i < 10 && flush_at_resp; i++) step();
      flush_in = 1'b0;
      chk("t4_empty_after_flush", {31'b0, inst_valid}, 32'd0);
      chk("t4_no_pop", pop_pc_q.size(), 32'd0);
      run_until_reqs(4, "t4");
      chk("t4_req_after_flush", req_addr_q[3], 32'h200);
      run_until_pops(1, "t4");
      chk("t4_pop_pc", pop_pc_q[0], 32'h200);
      chk("t4_pop_w", pop_w_q[0], 32'h00010013);

      // T5: rdy_in low for five cycles mid-request
      do_reset();
      inst_ready = 1'b1;
      run_until_reqs(3, "t5");
      rdy_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t5_frozen_req_valid", {31'b0, mem_req_valid}, 32'd1);
         chk("t5_frozen_req_addr", mem_req_addr, 32'h8);
      end
      rdy_in = 1'b1;
      run_until_reqs(6, "t5");
      chk("t5_gap_frozen", req_cyc_q[3] - req_cyc_q[2], 32'd9);
      chk("t5_gap_after", req_cyc_q[4] - req_cyc_q[3], 32'd4);
      run_until_pops(5, "t5");
      for (int i = 0; i < 5; i++) chk("t5_pop_pc", pop_pc_q[i], 32'(i * 4));

      // T6: JAL word at pc 0x20
      do_reset();
      jal_mode   = 1'b1;
      inst_ready = 1'b1;
      run_until_reqs(10, "t6");
      chk("t6_req_jal", req_addr_q[8], 32'h20);
      chk("t6_req_after_jal", req_addr_q[9], JAL_NEXT);
      run_until_pops(10, "t6");
      chk("t6_pop_w_jal", pop_w_q[8], 32'h0080006F);
      chk("t6_pop_pred", {31'b0, pop_p_q[8]}, {31'b0, JAL_PRED});
      chk("t6_pop_pc_after_jal", pop_pc_q[9], JAL_NEXT);
      jal_mode = 1'b0;

      // T7: fetch PC wraps from 0xFFFFFFFC to 0
      do_reset();
      inst_ready = 1'b1;
      flush_in   = 1'b1;
      flush_pc   = 32'hFFFFFFFC;
      step();
      flush_in = 1'b0;
      run_until_reqs(2, "t7");
      chk("t7_req_top", req_addr_q[0], 32'hFFFFFFFC);
      chk("t7_req_wrap", req_addr_q[1], 32'h0);
      run_until_pops(1, "t7");
      chk("t7_pop_pc", pop_pc_q[0], 32'hFFFFFFFC);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
